// File: rtl/mem_master_pkg.sv
// Shared types and constants for the core-to-AXI-lite memory master.
// The latched request is sized for the default 64-bit bus.
package mem_master_pkg;

  localparam int MM_ADDR_W = 64;
  localparam int MM_DATA_W = 64;
  localparam int MM_STRB_W = MM_DATA_W / 8;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_WRESP,
    ST_RADDR,
    ST_RDATA,
    ST_DONE
  } state_t;

  typedef struct packed {
    logic [MM_ADDR_W-1:0] addr;
    logic [MM_DATA_W-1:0] wdata;
    logic [MM_STRB_W-1:0] mask;
    logic                 is_write;
  } mem_req_t;

  // EXOKAY (2'b01) has no meaning on AXI-lite, so anything but OKAY is an error.
  function automatic logic resp_is_err(input logic [1:0] resp);
    return resp != RESP_OKAY;
  endfunction

endpackage

// File: rtl/axi_lite_wr_tracker.sv
// Tracks completion of the AW and W handshakes of one AXI-lite write.
// both_done includes handshakes happening in the current cycle.
module axi_lite_wr_tracker (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_aw_hs,
  input  logic i_w_hs,
  output logic o_aw_done,
  output logic o_w_done,
  output logic o_both_done
);

  logic r_aw_done;
  logic r_w_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else if (i_clear) begin
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else begin
      if (i_aw_hs) r_aw_done <= 1'b1;
      if (i_w_hs)  r_w_done  <= 1'b1;
    end
  end

  assign o_aw_done   = r_aw_done;
  assign o_w_done    = r_w_done;
  assign o_both_done = (r_aw_done | i_aw_hs) & (r_w_done | i_w_hs);

endmodule

// File: rtl/axi_lite_mem_master.sv
// Turns each core load/store into exactly one AXI-lite transaction,
// one outstanding at a time, with registered response capture.
//
// state    | meaning
// IDLE     | waiting for ren_i/wen_i; only state that samples the request
// WRITE    | AW and W offered, each dropped after its own handshake
// WRESP    | bready high, waiting for the write response
// RADDR    | AR offered
// RDATA    | rready high, waiting for read data
// DONE     | one-cycle valid_o/err_o pulse back to the core
module axi_lite_mem_master
  import mem_master_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 64,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] address_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [STRB_WIDTH-1:0] mask_i,
  input  logic                  ren_i,
  input  logic                  wen_i,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  valid_o,
  output logic                  err_o,
  output logic                  busy_o,
  output logic [ADDR_WIDTH-1:0] awaddr,
  output logic                  awvalid,
  input  logic                  awready,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic [STRB_WIDTH-1:0] wstrb,
  output logic                  wvalid,
  input  logic                  wready,
  input  logic [1:0]            bresp,
  input  logic                  bvalid,
  output logic                  bready,
  output logic [ADDR_WIDTH-1:0] araddr,
  output logic                  arvalid,
  input  logic                  arready,
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic [1:0]            rresp,
  input  logic                  rvalid,
  output logic                  rready
);

  state_t                r_state;
  state_t                w_state_nxt;
  mem_req_t              r_req;
  mem_req_t              w_req_nxt;
  logic                  r_conflict, w_conflict_nxt;
  logic                  r_err, w_err_nxt;
  logic [DATA_WIDTH-1:0] r_rdata, w_rdata_nxt;
  logic                  r_awvalid, w_awvalid_nxt;
  logic                  r_wvalid, w_wvalid_nxt;
  logic                  r_bready, w_bready_nxt;
  logic                  r_arvalid, w_arvalid_nxt;
  logic                  r_rready, w_rready_nxt;

  logic w_aw_hs;
  logic w_w_hs;
  logic w_aw_done;
  logic w_w_done;
  logic w_both_done;
  logic w_clear;

  assign w_aw_hs = r_awvalid & awready;
  assign w_w_hs  = r_wvalid & wready;
  assign w_clear = (r_state == ST_IDLE);

  axi_lite_wr_tracker u_wr_tracker (
    .clk         (clk),
    .rst         (rst),
    .i_clear     (w_clear),
    .i_aw_hs     (w_aw_hs),
    .i_w_hs      (w_w_hs),
    .o_aw_done   (w_aw_done),
    .o_w_done    (w_w_done),
    .o_both_done (w_both_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_req_nxt      = r_req;
    w_conflict_nxt = r_conflict;
    w_err_nxt      = r_err;
    w_rdata_nxt    = r_rdata;
    w_awvalid_nxt  = r_awvalid;
    w_wvalid_nxt   = r_wvalid;
    w_bready_nxt   = r_bready;
    w_arvalid_nxt  = r_arvalid;
    w_rready_nxt   = r_rready;

    case (r_state)
      ST_IDLE: begin
        if (wen_i) begin
          w_req_nxt.addr     = MM_ADDR_W'(address_i);
          w_req_nxt.wdata    = MM_DATA_W'(wdata_i);
          w_req_nxt.mask     = MM_STRB_W'(mask_i);
          w_req_nxt.is_write = 1'b1;
          w_conflict_nxt     = ren_i;
          w_err_nxt          = 1'b0;
          w_awvalid_nxt      = 1'b1;
          w_wvalid_nxt       = 1'b1;
          w_state_nxt        = ST_WRITE;
        end else if (ren_i) begin
          w_req_nxt.addr     = MM_ADDR_W'(address_i);
          w_req_nxt.wdata    = '0;
          w_req_nxt.mask     = '0;
          w_req_nxt.is_write = 1'b0;
          w_conflict_nxt     = 1'b0;
          w_err_nxt          = 1'b0;
          w_arvalid_nxt      = 1'b1;
          w_state_nxt        = ST_RADDR;
        end
      end
      ST_WRITE: begin
        w_awvalid_nxt = !(w_aw_done || w_aw_hs);
        w_wvalid_nxt  = !(w_w_done || w_w_hs);
        if (w_both_done) begin
          w_bready_nxt = 1'b1;
          w_state_nxt  = ST_WRESP;
        end
      end
      ST_WRESP: begin
        if (bvalid && r_bready) begin
          w_err_nxt    = resp_is_err(bresp) | r_conflict;
          w_bready_nxt = 1'b0;
          w_state_nxt  = ST_DONE;
        end
      end
      ST_RADDR: begin
        if (r_arvalid && arready) begin
          w_arvalid_nxt = 1'b0;
          w_rready_nxt  = 1'b1;
          w_state_nxt   = ST_RDATA;
        end
      end
      ST_RDATA: begin
        if (rvalid && r_rready) begin
          w_rdata_nxt  = rdata;
          w_err_nxt    = resp_is_err(rresp);
          w_rready_nxt = 1'b0;
          w_state_nxt  = ST_DONE;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // All AXI valids/readies are flops, so no ready can reach a valid combinationally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_req      <= '0;
      r_conflict <= 1'b0;
      r_err      <= 1'b0;
      r_rdata    <= '0;
      r_awvalid  <= 1'b0;
      r_wvalid   <= 1'b0;
      r_bready   <= 1'b0;
      r_arvalid  <= 1'b0;
      r_rready   <= 1'b0;
    end else begin
      r_req      <= w_req_nxt;
      r_conflict <= w_conflict_nxt;
      r_err      <= w_err_nxt;
      r_rdata    <= w_rdata_nxt;
      r_awvalid  <= w_awvalid_nxt;
      r_wvalid   <= w_wvalid_nxt;
      r_bready   <= w_bready_nxt;
      r_arvalid  <= w_arvalid_nxt;
      r_rready   <= w_rready_nxt;
    end
  end

  // Address buses stay quiet on the channel the current request does not use.
  assign awaddr  = r_req.is_write ? r_req.addr[ADDR_WIDTH-1:0] : '0;
  assign araddr  = r_req.is_write ? '0 : r_req.addr[ADDR_WIDTH-1:0];
  assign wdata   = r_req.wdata[DATA_WIDTH-1:0];
  assign wstrb   = r_req.mask[STRB_WIDTH-1:0];
  assign awvalid = r_awvalid;
  assign wvalid  = r_wvalid;
  assign bready  = r_bready;
  assign arvalid = r_arvalid;
  assign rready  = r_rready;

  assign rdata_o = r_rdata;
  assign valid_o = (r_state == ST_DONE);
  assign err_o   = (r_state == ST_DONE) & r_err;
  assign busy_o  = (r_state != ST_IDLE);

endmodule

// File: tb/tb_axi_lite_mem_master.sv
// Directed and randomized bench: a delay-configurable AXI-lite slave plus a
// transaction-level model of latency, error and rdata_o expectations.
module tb_axi_lite_mem_master;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] address_i, wdata_i;
  logic [7:0]  mask_i;
  logic        ren_i, wen_i;
  logic [63:0] rdata_o;
  logic        valid_o, err_o, busy_o;
  logic [63:0] awaddr;
  logic        awvalid, awready;
  logic [63:0] wdata;
  logic [7:0]  wstrb;
  logic        wvalid, wready;
  logic [1:0]  bresp;
  logic        bvalid, bready;
  logic [63:0] araddr;
  logic        arvalid, arready;
  logic [63:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid, rready;

  int checks = 0;
  int errors = 0;

  // slave configuration
  int          cfg_aw_d, cfg_w_d, cfg_b_d, cfg_ar_d, cfg_r_d;
  logic [1:0]  cfg_bresp, cfg_rresp;
  logic [63:0] cfg_rdata;

  // slave observations
  int          n_aw, n_w, n_ar;
  logic [63:0] cap_awaddr, cap_wdata, cap_araddr;
  logic [7:0]  cap_wstrb;

  // model state
  logic [63:0] exp_rdata;
  bit          saw_w_only;

  axi_lite_mem_master #(.DATA_WIDTH(64), .ADDR_WIDTH(64)) dut (
    .clk(clk), .rst(rst),
    .address_i(address_i), .wdata_i(wdata_i), .mask_i(mask_i),
    .ren_i(ren_i), .wen_i(wen_i),
    .rdata_o(rdata_o), .valid_o(valid_o), .err_o(err_o), .busy_o(busy_o),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // AXI-lite slave: updates at negedge; a handshake at a posedge is seen as
  // (valid at previous negedge) && (ready we were driving).
  initial begin : slave
    logic        p_awvalid, p_wvalid, p_arvalid, p_bready, p_rready;
    logic [63:0] p_awaddr, p_wdata, p_araddr;
    logic [7:0]  p_wstrb;
    bit          aw_hs, w_hs, b_hs, ar_hs, r_hs, got_aw, got_w, got_ar;
    int          aw_wait, w_wait, b_wait, ar_wait, r_wait;
    awready = 0; wready = 0; bvalid = 0; bresp = 0;
    arready = 0; rvalid = 0; rresp = 0; rdata = 0;
    p_awvalid = 0; p_wvalid = 0; p_arvalid = 0; p_bready = 0; p_rready = 0;
    p_awaddr = 0; p_wdata = 0; p_araddr = 0; p_wstrb = 0;
    got_aw = 0; got_w = 0; got_ar = 0;
    aw_wait = 0; w_wait = 0; b_wait = 0; ar_wait = 0; r_wait = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
        p_awvalid = 0; p_wvalid = 0; p_arvalid = 0; p_bready = 0; p_rready = 0;
        got_aw = 0; got_w = 0; got_ar = 0;
        aw_wait = 0; w_wait = 0; b_wait = 0; ar_wait = 0; r_wait = 0;
        continue;
      end
      aw_hs = p_awvalid && awready;
      w_hs  = p_wvalid && wready;
      b_hs  = bvalid && p_bready;
      ar_hs = p_arvalid && arready;
      r_hs  = rvalid && p_rready;
      if (p_awvalid && !aw_hs) begin
        chk("aw_hold", awvalid, 1);
        chk("aw_stable", awaddr, p_awaddr);
      end
      if (p_wvalid && !w_hs) begin
        chk("w_hold", wvalid, 1);
        chk("w_stable", wdata, p_wdata);
        chk("wstrb_stable", wstrb, p_wstrb);
      end
      if (p_arvalid && !ar_hs) begin
        chk("ar_hold", arvalid, 1);
        chk("ar_stable", araddr, p_araddr);
      end
      if (aw_hs) begin n_aw++; cap_awaddr = p_awaddr; got_aw = 1; awready = 0; aw_wait = 0; end
      if (w_hs)  begin n_w++; cap_wdata = p_wdata; cap_wstrb = p_wstrb; got_w = 1; wready = 0; w_wait = 0; end
      if (b_hs)  begin bvalid = 0; got_aw = 0; got_w = 0; end
      if (ar_hs) begin n_ar++; cap_araddr = p_araddr; got_ar = 1; arready = 0; ar_wait = 0; end
      if (r_hs)  begin rvalid = 0; got_ar = 0; end
      if (awvalid && !awready && !aw_hs) begin
        if (aw_wait >= cfg_aw_d) awready = 1; else aw_wait++;
      end
      if (wvalid && !wready && !w_hs) begin
        if (w_wait >= cfg_w_d) wready = 1; else w_wait++;
      end
      if (arvalid && !arready && !ar_hs) begin
        if (ar_wait >= cfg_ar_d) arready = 1; else ar_wait++;
      end
      if (got_aw && got_w && !bvalid) begin
        if (b_wait >= cfg_b_d) begin bvalid = 1; bresp = cfg_bresp; b_wait = 0; end
        else b_wait++;
      end
      if (got_ar && !rvalid) begin
        if (r_wait >= cfg_r_d) begin rvalid = 1; rresp = cfg_rresp; rdata = cfg_rdata; r_wait = 0; end
        else r_wait++;
      end
      p_awvalid = awvalid; p_wvalid = wvalid; p_arvalid = arvalid;
      p_bready = bready; p_rready = rready;
      p_awaddr = awaddr; p_wdata = wdata; p_wstrb = wstrb; p_araddr = araddr;
    end
  end

  task automatic set_cfg(input int aw, input int w, input int b, input int ar, input int r,
                         input logic [1:0] br, input logic [1:0] rr, input logic [63:0] rd);
    cfg_aw_d = aw; cfg_w_d = w; cfg_b_d = b; cfg_ar_d = ar; cfg_r_d = r;
    cfg_bresp = br; cfg_rresp = rr; cfg_rdata = rd;
  endtask

  // One core request checked against the transaction-level model.
  task automatic run_txn(input logic w, input logic r, input logic [63:0] a,
                         input logic [63:0] d, input logic [7:0] m, input string tag);
    int   exp_lat, cyc;
    bit   done;
    logic exp_err;
    exp_lat = w ? 3 + ((cfg_aw_d > cfg_w_d) ? cfg_aw_d : cfg_w_d) + cfg_b_d
                : 3 + cfg_ar_d + cfg_r_d;
    exp_err = w ? ((cfg_bresp != 2'b00) || r) : (cfg_rresp != 2'b00);
    n_aw = 0; n_w = 0; n_ar = 0; saw_w_only = 0;
    @(negedge clk);
    address_i = a; wdata_i = d; mask_i = m; wen_i = w; ren_i = r;
    cyc = 0; done = 0;
    while (!done && cyc < 60) begin
      @(posedge clk); #1;
      cyc++;
      if (!awvalid && wvalid) saw_w_only = 1;
      chk({tag, ".busy"}, busy_o, 1);
      if (valid_o) done = 1;
    end
    wen_i = 0; ren_i = 0;
    if (!done) chk({tag, ".timeout"}, valid_o, 1);
    if (!w) exp_rdata = cfg_rdata;
    chk({tag, ".latency"}, cyc, exp_lat);
    chk({tag, ".err"}, err_o, exp_err);
    chk({tag, ".rdata_o"}, rdata_o, exp_rdata);
    chk({tag, ".w_only"}, saw_w_only, w && (cfg_w_d > cfg_aw_d));
    if (w) begin
      chk({tag, ".n_aw"}, n_aw, 1);
      chk({tag, ".n_w"}, n_w, 1);
      chk({tag, ".n_ar"}, n_ar, 0);
      chk({tag, ".awaddr"}, cap_awaddr, a);
      chk({tag, ".wdata"}, cap_wdata, d);
      chk({tag, ".wstrb"}, cap_wstrb, m);
    end else begin
      chk({tag, ".n_ar"}, n_ar, 1);
      chk({tag, ".n_aw"}, n_aw, 0);
      chk({tag, ".araddr"}, cap_araddr, a);
    end
    @(posedge clk); #1;
    chk({tag, ".pulse"}, valid_o, 0);
    chk({tag, ".idle"}, busy_o, 0);
    chk({tag, ".hold"}, rdata_o, exp_rdata);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".busy"}, busy_o, 0);
    chk({tag, ".valid"}, valid_o, 0);
    chk({tag, ".err"}, err_o, 0);
    chk({tag, ".rdata_o"}, rdata_o, 0);
    chk({tag, ".valids"}, {awvalid, wvalid, arvalid}, 0);
    chk({tag, ".readies"}, {bready, rready}, 0);
    chk({tag, ".addrs"}, awaddr | araddr, 0);
  endtask

  initial begin
    logic [1:0] resp_tab [4];
    resp_tab[0] = 2'b00; resp_tab[1] = 2'b00; resp_tab[2] = 2'b10; resp_tab[3] = 2'b11;
    rst = 1; address_i = 0; wdata_i = 0; mask_i = 0; ren_i = 0; wen_i = 0;
    exp_rdata = 0;
    set_cfg(0, 0, 0, 0, 0, 2'b00, 2'b00, 64'h0);
    #12;
    chk_all_zero("reset");
    @(posedge clk); #2 rst = 0;

    run_txn(1, 0, 64'h0200_4000, 64'h0000_0000_0000_1234, 8'hFF, "store");

    set_cfg(0, 0, 0, 0, 3, 2'b00, 2'b00, 64'h5A5A);
    run_txn(0, 1, 64'h0200_BFF8, 64'h0, 8'h00, "load_wait");

    set_cfg(0, 2, 0, 0, 0, 2'b00, 2'b00, 64'h0);
    run_txn(1, 0, 64'h0200_4008, 64'hDEAD_BEEF_0000_0001, 8'h0F, "aw_first");

    set_cfg(0, 0, 0, 1, 1, 2'b00, 2'b10, 64'hCAFE_F00D_1234_5678);
    run_txn(0, 1, 64'h0200_0010, 64'h0, 8'h00, "rd_slverr");

    set_cfg(1, 0, 1, 0, 0, 2'b00, 2'b00, 64'h0);
    run_txn(1, 1, 64'h0200_4010, 64'h1111_2222_3333_4444, 8'hF0, "conflict");

    // reset while waiting for read data
    set_cfg(0, 0, 0, 0, 10, 2'b00, 2'b00, 64'h7777);
    @(negedge clk);
    address_i = 64'h0200_0020; ren_i = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("rdata_state.rready", rready, 1);
    #2 rst = 1;
    #1;
    ren_i = 0;
    exp_rdata = 0;
    chk_all_zero("async_rst");
    repeat (2) @(posedge clk);
    #2 rst = 0;
    set_cfg(0, 0, 0, 0, 0, 2'b00, 2'b00, 64'h0BAD_C0DE);
    run_txn(0, 1, 64'h0200_0028, 64'h0, 8'h00, "after_rst");

    for (int i = 0; i < 24; i++) begin
      int          kind;
      logic [63:0] a, d;
      kind = $urandom_range(0, 9);
      a = {$urandom, $urandom};
      d = {$urandom, $urandom};
      set_cfg($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2),
              $urandom_range(0, 3), $urandom_range(0, 3),
              resp_tab[$urandom_range(0, 3)], resp_tab[$urandom_range(0, 3)],
              {$urandom, $urandom});
      if (kind < 4)      run_txn(1, 0, a, d, 8'($urandom_range(0, 255)), "rnd_wr");
      else if (kind < 9) run_txn(0, 1, a, d, 8'h00, "rnd_rd");
      else               run_txn(1, 1, a, d, 8'($urandom_range(0, 255)), "rnd_both");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
